// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-stage control/status bundle for pc_unit.
//   master modport : drives sequencing controls (advance/jump/branch/call/ret,
//                    stall/halt/resume plus jump_loc and branch_off), observes status.
//   slave modport  : pc_unit side; receives the controls, drives pc, fetch_addr,
//                    fetch_valid, halted, ras_count, ras_ovf and ras_unf.
interface pc_unit_if #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             advance;
    logic             jump;
    logic [WIDTH-1:0] jump_loc;
    logic             branch;
    logic [WIDTH-1:0] branch_off;
    logic             call;
    logic             ret;
    logic             stall;
    logic             halt;
    logic             resume;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] fetch_addr;
    logic             fetch_valid;
    logic             halted;
    logic [CW-1:0]    ras_count;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output advance, jump, jump_loc, branch, branch_off, call, ret,
               stall, halt, resume,
        input  pc, fetch_addr, fetch_valid, halted, ras_count, ras_ovf, ras_unf
    );

    modport slave (
        input  advance, jump, jump_loc, branch, branch_off, call, ret,
               stall, halt, resume,
        output pc, fetch_addr, fetch_valid, halted, ras_count, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with return-address stack.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pc_unit_if slave -- control ops in, pc / fetch strobe / RAS status out
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | executing at most one control op per cycle (ret>call>jump>branch>advance)
// ST_HALTED | pc frozen, controls ignored, waiting for resume without halt
module pc_unit #(
    parameter int               WIDTH     = 16,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               INC       = 1
) (
    input logic      clk,
    input logic      rst,
    pc_unit_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
    localparam logic [CW-1:0]    FULL_C = CW'(RAS_DEPTH);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] fetch_addr_q;
    logic             fetch_valid_q;
    logic             halted_q;
    logic [CW-1:0]    ras_cnt_q;
    logic [PW-1:0]    sp_q;          // next push slot; top lives at sp_q-1
    logic             ras_ovf_q;
    logic             ras_unf_q;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             run_ok;
    logic             do_ret, do_call, any_op;
    logic             ras_empty, ras_full;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] ras_top;

    always_comb begin
        run_ok    = (state_q == ST_RUN) && !bus.stall && !bus.halt;
        ras_empty = (ras_cnt_q == '0);
        ras_full  = (ras_cnt_q == FULL_C);
        pc_inc    = pc_q + INC_W;
        ras_top   = ras_q[sp_q - PW'(1)];
        do_ret    = run_ok && bus.ret;
        do_call   = run_ok && bus.call && !bus.ret;
        any_op    = run_ok && (bus.ret || bus.call || bus.jump ||
                               bus.branch || bus.advance);

        pc_d = pc_q;
        if (bus.ret)          pc_d = ras_empty ? pc_inc : ras_top;
        else if (bus.call)    pc_d = bus.jump_loc;
        else if (bus.jump)    pc_d = bus.jump_loc;
        else if (bus.branch)  pc_d = pc_q + bus.branch_off;  // wraps; offset is two's complement
        else if (bus.advance) pc_d = pc_inc;
    end

    // Stack storage carries no reset; occupancy and pointer define what is live.
    // When full, sp_q points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (do_call) ras_q[sp_q] <= pc_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_VEC;
            fetch_addr_q  <= RESET_VEC;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            ras_cnt_q     <= '0;
            sp_q          <= '0;
            ras_ovf_q     <= 1'b0;
            ras_unf_q     <= 1'b0;
        end else begin
            fetch_valid_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (bus.halt) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else if (any_op) begin
                            pc_q          <= pc_d;
                            fetch_addr_q  <= pc_d;
                            fetch_valid_q <= 1'b1;
                            if (do_ret) begin
                                if (ras_empty) begin
                                    ras_unf_q <= 1'b1;
                                end else begin
                                    sp_q      <= sp_q - PW'(1);
                                    ras_cnt_q <= ras_cnt_q - CW'(1);
                                end
                            end else if (do_call) begin
                                sp_q <= sp_q + PW'(1);
                                if (ras_full) ras_ovf_q <= 1'b1;
                                else          ras_cnt_q <= ras_cnt_q + CW'(1);
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    if (!bus.stall && bus.resume && !bus.halt) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_addr  = fetch_addr_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.halted      = halted_q;
    assign bus.ras_count   = ras_cnt_q;
    assign bus.ras_ovf     = ras_ovf_q;
    assign bus.ras_unf     = ras_unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random checks of pc_unit against a queue-based model.
module tb_pc_unit;
    localparam int          WIDTH = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RVEC  = 16'h0040;
    localparam logic [15:0] INC   = 16'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();

    pc_unit #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH), .RESET_VEC(RVEC), .INC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [15:0] m_pc, m_fa;
    logic        m_fv, m_halted, m_ovf, m_unf;
    logic [15:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RVEC; m_fa = RVEC; m_fv = 1'b0;
        m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_ras.delete();
    endtask

    // One clock of architectural behaviour, from the current inputs.
    task automatic model_step();
        logic op;
        op = 1'b1;
        if (bus.stall) begin
            op = 1'b0;
        end else if (m_halted) begin
            if (bus.resume && !bus.halt) m_halted = 1'b0;
            op = 1'b0;
        end else if (bus.halt) begin
            m_halted = 1'b1;
            op = 1'b0;
        end else if (bus.ret) begin
            if (m_ras.size() == 0) begin
                m_unf = 1'b1;
                m_pc  = m_pc + INC;
            end else begin
                m_pc = m_ras.pop_back();
            end
        end else if (bus.call) begin
            if (m_ras.size() == DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1'b1;
            end
            m_ras.push_back(m_pc + INC);
            m_pc = bus.jump_loc;
        end else if (bus.jump) begin
            m_pc = bus.jump_loc;
        end else if (bus.branch) begin
            m_pc = m_pc + bus.branch_off;
        end else if (bus.advance) begin
            m_pc = m_pc + INC;
        end else begin
            op = 1'b0;
        end
        m_fv = op;
        if (op) m_fa = m_pc;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},          32'(bus.pc),          32'(m_pc));
        chk({tag, ".fetch_addr"},  32'(bus.fetch_addr),  32'(m_fa));
        chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(m_fv));
        chk({tag, ".halted"},      32'(bus.halted),      32'(m_halted));
        chk({tag, ".ras_count"},   32'(bus.ras_count),   32'(m_ras.size()));
        chk({tag, ".ras_ovf"},     32'(bus.ras_ovf),     32'(m_ovf));
        chk({tag, ".ras_unf"},     32'(bus.ras_unf),     32'(m_unf));
    endtask

    task automatic clear_ins();
        bus.advance = 0; bus.jump = 0; bus.branch = 0; bus.call = 0; bus.ret = 0;
        bus.stall = 0; bus.halt = 0; bus.resume = 0;
        bus.jump_loc = '0; bus.branch_off = '0;
    endtask

    // Inputs are already set; model, clock, then sample 1 time unit after the edge.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        clear_ins();
    endtask

    task automatic do_adv(input string tag);
        bus.advance = 1; step(tag);
    endtask
    task automatic do_jump(input logic [15:0] a, input string tag);
        bus.jump = 1; bus.jump_loc = a; step(tag);
    endtask
    task automatic do_branch(input logic [15:0] o, input string tag);
        bus.branch = 1; bus.branch_off = o; step(tag);
    endtask
    task automatic do_call(input logic [15:0] a, input string tag);
        bus.call = 1; bus.jump_loc = a; step(tag);
    endtask
    task automatic do_ret(input string tag);
        bus.ret = 1; step(tag);
    endtask

    initial begin
        clear_ins();
        model_reset();

        // reset state
        #12;
        check_all("reset");
        chk("reset.pc_vec", 32'(bus.pc), 32'h0040);
        @(posedge clk); #1;
        rst = 1'b0;

        // sequential advance
        do_adv("adv1");
        do_adv("adv2");
        do_adv("adv3");
        chk("adv3.pc_abs", 32'(bus.pc), 32'h0043);
        step("idle");

        // jump/branch with wrap
        do_jump(16'hFFFE, "jump_fffe");
        do_branch(16'h0003, "br_wrap");
        chk("br_wrap.pc_abs", 32'(bus.pc), 32'h0001);
        do_branch(16'hFFFF, "br_neg");
        chk("br_neg.pc_abs", 32'(bus.pc), 32'h0000);

        // nested call/return
        do_jump(16'h0010, "jump_10");
        do_call(16'h0100, "call1");
        do_call(16'h0200, "call2");
        do_ret("ret1");
        chk("ret1.pc_abs", 32'(bus.pc), 32'h0101);
        do_ret("ret2");
        chk("ret2.pc_abs", 32'(bus.pc), 32'h0011);

        // overflow / underflow
        for (int i = 0; i < 5; i++) do_call(16'h1000 + 16'(i * 16'h100), "ovf_call");
        chk("ovf.flag", 32'(bus.ras_ovf), 32'd1);
        for (int i = 0; i < 5; i++) do_ret("unf_ret");
        chk("unf.flag", 32'(bus.ras_unf), 32'd1);

        // call and ret together: only ret pops
        do_call(16'h0300, "pre_callret");
        bus.call = 1; bus.ret = 1; bus.jump_loc = 16'h0777; step("call_ret_same");

        // stall beats jump
        bus.stall = 1; bus.jump = 1; bus.jump_loc = 16'h5555; step("stall_jump");
        // jump over branch over advance
        bus.jump = 1; bus.jump_loc = 16'h0ABC; bus.branch = 1; bus.branch_off = 16'h0010;
        bus.advance = 1; step("prio_jump");
        // halt discards same-cycle op, then frozen
        bus.halt = 1; bus.advance = 1; step("halt");
        do_adv("halted_adv");
        bus.halt = 1; bus.resume = 1; step("halt_resume_both");
        bus.resume = 1; bus.advance = 1; step("resume");
        do_adv("after_resume");

        // async reset between edges during a call
        bus.call = 1; bus.jump_loc = 16'h0F00;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        clear_ins();
        step("post_rst_idle");

        // random traffic
        for (int n = 0; n < 600; n++) begin
            bus.advance    = ($urandom_range(0, 99) < 40);
            bus.jump       = ($urandom_range(0, 99) < 10);
            bus.branch     = ($urandom_range(0, 99) < 15);
            bus.call       = ($urandom_range(0, 99) < 14);
            bus.ret        = ($urandom_range(0, 99) < 14);
            bus.stall      = ($urandom_range(0, 99) < 8);
            bus.halt       = ($urandom_range(0, 99) < 4);
            bus.resume     = ($urandom_range(0, 99) < 30);
            bus.jump_loc   = 16'($urandom);
            bus.branch_off = 16'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Holds the architectural PC and presents a registered fetch address with a valid strobe.
- Supports sequential advance, absolute jump, signed relative branch, and call/return through an internal return-address stack (RAS).
- Adds stall, halt, reset vector and RAS overflow/underflow error reporting.

Parameters:
WIDTH, 16, PC and address width in bits
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_VEC, 0, PC value loaded on reset
INC, 1, sequential increment added per advance

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
advance  input  1  sequential step: PC <= PC + INC
jump  input  1  absolute redirect to jump_loc
jump_loc  input  WIDTH  absolute target
branch  input  1  relative redirect
branch_off  input  WIDTH  signed two's-complement offset, added to current PC
call  input  1  push PC+INC, then redirect to jump_loc
ret  input  1  pop RAS top into PC
stall  input  1  freeze all state this cycle
halt  input  1  enter HALTED state
resume  input  1  leave HALTED state
pc  output  WIDTH  current architectural PC (registered)
fetch_addr  output  WIDTH  registered fetch address
fetch_valid  output  1  one-cycle strobe: fetch_addr valid
halted  output  1  high while in HALTED
ras_count  output  log2(RAS_DEPTH)+1  current RAS occupancy
ras_ovf  output  1  sticky: call with RAS full
ras_unf  output  1  sticky: ret with RAS empty

Behaviour:
- Reset (async, any time, including mid-operation): pc=RESET_VEC, fetch_addr=RESET_VEC, fetch_valid=0, halted=0, ras_count=0, ras_ovf=0, ras_unf=0. State=RUN. RAS contents need not be cleared.
- State machine:
  - RUN: halt=1 -> HALTED; the same-cycle control op is discarded.
  - HALTED: pc frozen, fetch_valid=0, controls ignored; resume=1 -> RUN on the next edge.
  - halt and resume both high in HALTED: stay HALTED.
- stall=1 (RUN): no state change; fetch_valid=0. stall takes priority over every control input except reset.
- Control priority when several are asserted: ret > call > jump > branch > advance. Exactly one op executes per cycle; lower ops are dropped.
- Update rules (RUN, not stalled):
  - advance: pc <= pc+INC.
  - jump: pc <= jump_loc.
  - branch: pc <= pc + branch_off.
  - call: push pc+INC, pc <= jump_loc.
  - ret: pc <= top, pop.
- Arithmetic is modulo 2^WIDTH (wrap-around, no flag). branch_off is sign-interpreted, so 0xFFFF with WIDTH=16 means -1.
- Fetch output: any executed op sets fetch_addr <= new pc and fetch_valid=1 for exactly the next cycle. No op executed -> fetch_valid=0. Latency from op to fetch_valid is 1 clock.
- RAS boundaries:
  - call with ras_count==RAS_DEPTH: the redirect still occurs, the oldest entry is overwritten (circular), ras_count stays at RAS_DEPTH, and ras_ovf is set.
  - ret with ras_count==0: pc <= pc+INC (treated as advance), ras_unf is set.
  - Both flags are sticky until reset.
- A call and a ret on the same cycle: only ret executes (priority), so the stack pops.

Test Plan:
- Reset/advance: rst pulse, then advance x3 -> pc 0,1,2,3; fetch_valid high one cycle after each advance; all flags 0.
- Jump and branch with wrap: jump_loc=0xFFFE, then branch_off=0x0003 -> pc=0xFFFE, then 0x0001. Next, branch_off=0xFFFF -> pc=0x0000.
- Nested call/return: at pc=0x10, call 0x100; call 0x200; ret; ret -> pc 0x100, 0x200, 0x101, 0x11; ras_count 1,2,1,0.
- RAS overflow/underflow (RAS_DEPTH=4): five calls -> ras_ovf=1, ras_count=4. Five rets -> the fifth gives ras_unf=1 and pc=prev+1.
- Stall/halt/priority: stall with jump -> pc unchanged, fetch_valid=0. jump+branch+advance together -> jump target only. halt, then advance -> pc frozen, halted=1. resume -> halted=0 next edge.
- Async reset mid-operation: assert rst between edges during a call -> outputs reach reset values immediately without a clock; pc=RESET_VEC (test with RESET_VEC=0x0040).
